// File: rtl/arb_requester.sv
// arb_requester: two independent burst requesters in front of an external arbiter.
// Each channel queues one burst on a start pulse, requests the arbiter, and
// transfers len+1 beats on granted cycles. It then releases the request for one
// cycle and returns to idle.
// Optional feature macro: ARB_REQ_TIMEOUT_EN. When it is defined, a request that
// waits TIMEOUT_CYC cycles without a grant is abandoned and to_i pulses.
// When it is undefined, requests wait forever and to_0/to_1 are tied low.
module arb_requester #(
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_0,
   input  logic             start_1,
   input  logic [LEN_W-1:0] len_0,
   input  logic [LEN_W-1:0] len_1,
   input  logic             gnt_0,
   input  logic             gnt_1,
   output logic             req_0,
   output logic             req_1,
   output logic             beat_0,
   output logic             beat_1,
   output logic             done_0,
   output logic             done_1,
   output logic             drop_0,
   output logic             drop_1,
   output logic             to_0,
   output logic             to_1,
   output logic             proto_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      REL  = 2'd3
   } state_t;

   // An out-of-range wait limit is a build error, not a silent wrap.
   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("arb_requester: TIMEOUT_CYC must be in 2..255");
   end

   // Per-channel views of the scalar ports so both channels share one generate body.
   logic [1:0]       start_v;
   logic [1:0]       gnt_v;
   logic [LEN_W-1:0] len_v [2];
   logic [1:0]       req_v;
   logic [1:0]       beat_v;
   logic [1:0]       done_v;
   logic [1:0]       drop_v;
   logic [1:0]       to_v;
   logic [1:0]       quiet_v;   // channel in IDLE or REL, where a grant is illegal

   logic proto_reg;
   logic proto_next;

   assign start_v  = {start_1, start_0};
   assign gnt_v    = {gnt_1, gnt_0};
   assign len_v[0] = len_0;
   assign len_v[1] = len_1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         state_t           state_reg, state_next;
         logic [LEN_W-1:0] cnt_reg, cnt_next;
         logic             done_reg, done_next;
         logic             drop_reg, drop_next;
`ifdef ARB_REQ_TIMEOUT_EN
         localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
         logic [7:0]       wait_reg, wait_next;
         logic             to_reg, to_next;
`endif

         // State, beat counter and pulse registers; reset aborts any burst silently.
         always_ff @(posedge clock) begin
            if (reset) begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               done_reg  <= 1'b0;
               drop_reg  <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
               wait_reg  <= '0;
               to_reg    <= 1'b0;
`endif
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               done_reg  <= done_next;
               drop_reg  <= drop_next;
`ifdef ARB_REQ_TIMEOUT_EN
               wait_reg  <= wait_next;
               to_reg    <= to_next;
`endif
            end
         end

         // Next-state logic. done/to are raised on the transition into REL so
         // that they are high exactly while REL is the current state.
         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            done_next  = 1'b0;
            drop_next  = start_v[gi] && (state_reg != IDLE);
`ifdef ARB_REQ_TIMEOUT_EN
            wait_next  = wait_reg;
            to_next    = 1'b0;
`endif
            case (state_reg)
               IDLE: begin
                  if (start_v[gi]) begin
                     cnt_next   = len_v[gi];
                     state_next = REQ;
`ifdef ARB_REQ_TIMEOUT_EN
                     wait_next  = '0;
`endif
                  end
               end
               REQ: begin
                  // A grant on the expiry cycle still wins.
                  if (gnt_v[gi]) begin
                     state_next = XFER;
                  end
`ifdef ARB_REQ_TIMEOUT_EN
                  else if (wait_reg == WAIT_LAST) begin
                     state_next = REL;
                     to_next    = 1'b1;
                  end else begin
                     wait_next = wait_reg + 8'd1;
                  end
`endif
               end
               XFER: begin
                  // Without a grant the burst stalls with the counter held.
                  if (gnt_v[gi]) begin
                     if (cnt_reg == '0) begin
                        state_next = REL;
                        done_next  = 1'b1;
                     end else begin
                        cnt_next = cnt_reg - 1'b1;
                     end
                  end
               end
               REL: begin
                  state_next = IDLE;
               end
               default: begin
                  state_next = IDLE;
               end
            endcase
         end

         assign req_v[gi]   = (state_reg == REQ) || (state_reg == XFER);
         assign beat_v[gi]  = (state_reg == XFER) && gnt_v[gi];
         assign quiet_v[gi] = (state_reg == IDLE) || (state_reg == REL);
         assign done_v[gi]  = done_reg;
         assign drop_v[gi]  = drop_reg;
`ifdef ARB_REQ_TIMEOUT_EN
         assign to_v[gi]    = to_reg;
`else
         assign to_v[gi]    = 1'b0;
`endif
      end
   endgenerate

   // Arbiter protocol check: double grant, or a grant to a channel not requesting.
   always_comb begin
      proto_next = (gnt_0 && gnt_1) || ((gnt_v & quiet_v) != 2'b00);
   end

   // Register the protocol error so it is a clean one-cycle pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         proto_reg <= 1'b0;
      end else begin
         proto_reg <= proto_next;
      end
   end

   assign req_0     = req_v[0];
   assign req_1     = req_v[1];
   assign beat_0    = beat_v[0];
   assign beat_1    = beat_v[1];
   assign done_0    = done_v[0];
   assign done_1    = done_v[1];
   assign drop_0    = drop_v[0];
   assign drop_1    = drop_v[1];
   assign to_0      = to_v[0];
   assign to_1      = to_v[1];
   assign proto_err = proto_reg;

endmodule

// File: tb/tb_arb_requester.sv
// Directed testbench for arb_requester (default LEN_W=4, TIMEOUT_CYC=32).
// Build with ARB_REQ_TIMEOUT_EN defined to check the timeout variant.
module tb_arb_requester;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_0, start_1;
   logic [3:0] len_0, len_1;
   logic       gnt_0, gnt_1;
   logic       req_0, req_1, beat_0, beat_1, done_0, done_1;
   logic       drop_0, drop_1, to_0, to_1, proto_err;
   logic [10:0] outs;

   int n_checks = 0;
   int n_pass   = 0;
   int cnt_a, cnt_b, cnt_c;

   arb_requester #(.LEN_W(4), .TIMEOUT_CYC(32)) dut (
      .clock(clock), .reset(reset),
      .start_0(start_0), .start_1(start_1),
      .len_0(len_0), .len_1(len_1),
      .gnt_0(gnt_0), .gnt_1(gnt_1),
      .req_0(req_0), .req_1(req_1),
      .beat_0(beat_0), .beat_1(beat_1),
      .done_0(done_0), .done_1(done_1),
      .drop_0(drop_0), .drop_1(drop_1),
      .to_0(to_0), .to_1(to_1),
      .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   assign outs = {req_1, req_0, beat_1, beat_0, done_1, done_0,
                  drop_1, drop_0, to_1, to_0, proto_err};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Advance to just after the next rising edge; inputs are then driven and
   // outputs sampled 2 time units later, well away from either edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      reset = 1'b1; start_0 = 0; start_1 = 0; len_0 = 0; len_1 = 0; gnt_0 = 0; gnt_1 = 0;
      cyc(); cyc();
      settle();
      chk("reset_outs", 32'(outs), 32'h0);
      reset = 1'b0;
      cyc();

      // Channel 0, len 3, grant held from the cycle req rises: 4 beats then done.
      start_0 = 1; len_0 = 4'd3; settle();
      chk("b0_idle_req", 32'(req_0), 32'd0);
      cyc(); start_0 = 0; len_0 = 4'd9; gnt_0 = 1; settle();
      chk("b0_req_rise", 32'(req_0), 32'd1);
      chk("b0_req_nobeat", 32'(beat_0), 32'd0);
      cnt_a = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(); settle();
         cnt_a += int'(beat_0 & req_0);
      end
      chk("b0_beats", 32'(cnt_a), 32'd4);
      cyc(); gnt_0 = 0; settle();
      chk("b0_rel_outs", 32'(outs), 32'b000001_00000);
      cyc(); settle();
      chk("b0_idle_outs", 32'(outs), 32'h0);
      $display("burst ch0 len=3 beats=%0d", cnt_a);

      // Channel 1, len 2, grant pattern 1,0,1,0,1 during XFER: beats follow grant.
      start_1 = 1; len_1 = 4'd2;
      cyc(); start_1 = 0; gnt_1 = 1; settle();
      chk("b1_req", 32'(req_1), 32'd1);
      cnt_b = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(); gnt_1 = ((i % 2) == 0); settle();
         chk($sformatf("b1_beat%0d", i), 32'(beat_1), 32'((i % 2) == 0));
         chk($sformatf("b1_req%0d", i), 32'(req_1), 32'd1);
         cnt_b += int'(beat_1);
      end
      cyc(); gnt_1 = 0; settle();
      chk("b1_done", 32'(done_1), 32'd1);
      chk("b1_req_low", 32'(req_1), 32'd0);
      chk("b1_beats", 32'(cnt_b), 32'd3);
      cyc(); settle();
      chk("b1_done_once", 32'(done_1), 32'd0);
      $display("burst ch1 len=2 beats=%0d", cnt_b);

      // Channel 0 restart during XFER is dropped and the burst length is kept.
      start_0 = 1; len_0 = 4'd1;
      cyc(); start_0 = 0; gnt_0 = 1;
      cyc(); start_0 = 1; len_0 = 4'd6; settle();
      chk("d0_beat1", 32'(beat_0), 32'd1);
      chk("d0_nodrop_yet", 32'(drop_0), 32'd0);
      cyc(); start_0 = 0; settle();
      chk("d0_drop", 32'(drop_0), 32'd1);
      chk("d0_beat2", 32'(beat_0), 32'd1);
      cyc(); gnt_0 = 0; settle();
      chk("d0_done", 32'(outs), 32'b000001_00000);
      cyc(); settle();
      chk("d0_single_done", 32'(done_0), 32'd0);
      $display("burst ch0 len=1 with dropped restart");

      // Protocol errors: double grant, then a grant to an idle channel.
      gnt_0 = 1; gnt_1 = 1; settle();
      chk("pe_same_cycle", 32'(proto_err), 32'd0);
      cyc(); gnt_0 = 0; gnt_1 = 0; settle();
      chk("pe_double", 32'(proto_err), 32'd1);
      cyc(); settle();
      chk("pe_clear", 32'(proto_err), 32'd0);
      gnt_0 = 1;
      cyc(); gnt_0 = 0; settle();
      chk("pe_idle_gnt", 32'(proto_err), 32'd1);
      chk("pe_fsm_idle", 32'(req_0), 32'd0);
      cyc(); settle();
      chk("pe_pulse", 32'(proto_err), 32'd0);
      $display("protocol error checks");

      // Reset at beat 2 of a len 7 burst aborts with no done, then a clean burst.
      start_0 = 1; len_0 = 4'd7;
      cyc(); start_0 = 0; gnt_0 = 1;
      cyc();
      cyc(); reset = 1; settle();
      chk("rs_beat2", 32'(beat_0), 32'd1);
      cyc(); reset = 0; gnt_0 = 0; settle();
      chk("rs_outs0", 32'(outs), 32'h0);
      cyc(); settle();
      chk("rs_no_done", 32'(outs), 32'h0);
      start_0 = 1; len_0 = 4'd0;
      cyc(); start_0 = 0; gnt_0 = 1; settle();
      chk("rs_req", 32'(req_0), 32'd1);
      cyc(); settle();
      chk("rs_beat", 32'(beat_0), 32'd1);
      cyc(); gnt_0 = 0; settle();
      chk("rs_done", 32'(outs), 32'b000001_00000);
      $display("burst ch0 aborted by reset, then len=0 burst");

      // Channel 1 request with no grant ever.
      cyc();
      start_1 = 1; len_1 = 4'd0;
      cyc(); start_1 = 0;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 40; i++) begin
         settle();
         cnt_a += int'(req_1);
         cnt_b += int'(to_1);
         cnt_c += int'(done_1);
         cyc();
      end
`ifdef ARB_REQ_TIMEOUT_EN
      chk("to_req_cycles", 32'(cnt_a), 32'd32);
      chk("to_pulses", 32'(cnt_b), 32'd1);
      chk("to_no_done", 32'(cnt_c), 32'd0);
      settle();
      chk("to_idle", 32'(req_1), 32'd0);
`else
      chk("nto_req_cycles", 32'(cnt_a), 32'd40);
      chk("nto_no_to", 32'(cnt_b), 32'd0);
      chk("nto_no_done", 32'(cnt_c), 32'd0);
      settle();
      chk("nto_still_req", 32'(req_1), 32'd1);
`endif
      $display("no-grant request ch1 req_cycles=%0d to_pulses=%0d", cnt_a, cnt_b);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
